// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, talks req/ack to instruction memory and loads IF/ID.
// Optional FETCH_PERF_CNT_EN adds stall_cycles / flush_count performance counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hazard_Detected,
   input  logic        Br_taken,
   input  logic [31:0] Br_offset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count,
`endif
   output logic [31:0] IF_ID_Instruction,
   output logic [31:0] IF_ID_PC,
   output logic        IF_ID_valid
);

   typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] addr_q, addr_d;
   logic        hold_valid_q, hold_valid_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic        ifid_valid_q, ifid_valid_d;

   logic        advance, redirect, busy_ack;
   logic [31:0] target;

   function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                 input logic signed [31:0] off);
      return pc + 32'(off <<< 2);
   endfunction

   assign advance  = !ifid_valid_q || !hazard_Detected;
   assign redirect = ifid_valid_q && Br_taken && !hazard_Detected;
   assign busy_ack = (state_q == BUSY) && imem_ack;
   assign target   = branch_target(ifid_pc_q, Br_offset);

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      addr_d       = addr_q;
      hold_valid_d = hold_valid_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;

      if (redirect) begin
         ifid_instr_d = 32'h0;
         ifid_pc_d    = 32'h0;
         ifid_valid_d = 1'b0;
         hold_valid_d = 1'b0;
         fetch_pc_d   = target;
         // An un-acked request cannot be withdrawn; its response must be swallowed first.
         if (state_q != IDLE && !imem_ack) begin
            state_d = DROP;
         end else begin
            state_d = BUSY;
            addr_d  = target;
         end
      end else begin
         if (advance) begin
            if (hold_valid_q) begin
               ifid_instr_d = hold_instr_q;
               ifid_pc_d    = hold_pc_q;
               ifid_valid_d = 1'b1;
               hold_valid_d = 1'b0;
            end else if (busy_ack) begin
               ifid_instr_d = imem_rdata;
               ifid_pc_d    = addr_q + 32'd4;
               ifid_valid_d = 1'b1;
            end else begin
               ifid_instr_d = 32'h0;
               ifid_pc_d    = 32'h0;
               ifid_valid_d = 1'b0;
            end
         end else if (busy_ack) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = addr_q + 32'd4;
            hold_valid_d = 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (!hold_valid_q || advance) begin
                  state_d = BUSY;
                  addr_d  = fetch_pc_q;
               end
            end
            BUSY: begin
               if (imem_ack) begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  if (advance) begin
                     addr_d = fetch_pc_q + 32'd4;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            DROP: begin
               if (imem_ack) begin
                  state_d = BUSY;
                  addr_d  = fetch_pc_q;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         fetch_pc_q   <= RESET_PC;
         addr_q       <= 32'h0;
         hold_valid_q <= 1'b0;
         hold_instr_q <= 32'h0;
         hold_pc_q    <= 32'h0;
         ifid_instr_q <= 32'h0;
         ifid_pc_q    <= 32'h0;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         addr_q       <= addr_d;
         hold_valid_q <= hold_valid_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
      end else begin
         if (hazard_Detected && ifid_valid_q) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (redirect)                        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
`endif

   assign imem_req          = (state_q != IDLE);
   assign imem_addr         = addr_q;
   assign IF_ID_Instruction = ifid_instr_q;
   assign IF_ID_PC          = ifid_pc_q;
   assign IF_ID_valid       = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model returns (address + K) after a programmable latency.
module tb_fetch_unit;

   localparam logic [31:0] K = 32'hA000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        hazard_Detected;
   logic        Br_taken;
   logic [31:0] Br_offset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] IF_ID_Instruction;
   logic [31:0] IF_ID_PC;
   logic        IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
`endif

   int checks = 0;
   int failures = 0;
   int mem_lat = 0;
   int cnt = 0;
   logic ack_force = 1'b0;

   fetch_unit dut (
      .clk              (clk),
      .rst              (rst),
      .hazard_Detected  (hazard_Detected),
      .Br_taken         (Br_taken),
      .Br_offset        (Br_offset),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ack         (imem_ack),
      .imem_rdata       (imem_rdata),
`ifdef FETCH_PERF_CNT_EN
      .stall_cycles     (stall_cycles),
      .flush_count      (flush_count),
`endif
      .IF_ID_Instruction(IF_ID_Instruction),
      .IF_ID_PC         (IF_ID_PC),
      .IF_ID_valid      (IF_ID_valid)
   );

   always #5 clk = ~clk;

   assign imem_ack   = ack_force || (imem_req && (cnt >= mem_lat));
   assign imem_rdata = imem_addr + K;

   always @(posedge clk) begin
      if (!rst || !imem_req || imem_ack) cnt <= 0;
      else cnt <= cnt + 1;
   end

   task automatic test_reset;
      rst = 1'b0; hazard_Detected = 1'b0; Br_taken = 1'b0; Br_offset = 32'h0;
      ack_force = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
      checks++; if (IF_ID_Instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", IF_ID_Instruction); end
      checks++; if (IF_ID_PC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", IF_ID_PC); end
      checks++; if (IF_ID_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", IF_ID_valid); end
      ack_force = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_stream;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req got req=%0b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
      checks++; if (IF_ID_valid !== 1'b0) begin failures++; $display("FAIL first_bubble got=%0b exp=0", IF_ID_valid); end
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checks++;
         if (IF_ID_valid !== 1'b1 || IF_ID_PC !== 32'(4*i) || IF_ID_Instruction !== 32'(4*(i-1)) + K) begin
            failures++;
            $display("FAIL stream_%0d got v=%0b pc=%h ins=%h exp v=1 pc=%h ins=%h", i, IF_ID_valid, IF_ID_PC, IF_ID_Instruction, 32'(4*i), 32'(4*(i-1)) + K);
         end
      end
   endtask

   task automatic test_stall_hold;
      @(negedge clk);
      checks++; if (imem_addr !== 32'h10 || imem_ack !== 1'b1 || IF_ID_PC !== 32'h10) begin failures++; $display("FAIL pre_stall got addr=%h pc=%h exp addr=10 pc=10", imem_addr, IF_ID_PC); end
      hazard_Detected = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (IF_ID_PC !== 32'h10 || IF_ID_Instruction !== 32'hC + K || IF_ID_valid !== 1'b1 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_frozen_%0d got pc=%h ins=%h v=%0b req=%0b exp pc=10 ins=%h v=1 req=0", i, IF_ID_PC, IF_ID_Instruction, IF_ID_valid, imem_req, 32'hC + K);
         end
      end
      hazard_Detected = 1'b0;
      @(negedge clk);
      checks++; if (IF_ID_Instruction !== 32'h10 + K || IF_ID_PC !== 32'h14 || IF_ID_valid !== 1'b1) begin failures++; $display("FAIL hold_drain got ins=%h pc=%h v=%0b exp ins=%h pc=14 v=1", IF_ID_Instruction, IF_ID_PC, IF_ID_valid, 32'h10 + K); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin failures++; $display("FAIL post_drain_req got req=%0b addr=%h exp req=1 addr=14", imem_req, imem_addr); end
      @(negedge clk);
      checks++; if (IF_ID_PC !== 32'h18 || IF_ID_Instruction !== 32'h14 + K) begin failures++; $display("FAIL after_drain got pc=%h ins=%h exp pc=18 ins=%h", IF_ID_PC, IF_ID_Instruction, 32'h14 + K); end
   endtask

   task automatic test_branch;
      repeat (2) @(negedge clk);
      checks++; if (IF_ID_PC !== 32'h20 || IF_ID_valid !== 1'b1) begin failures++; $display("FAIL pre_branch got pc=%h v=%0b exp pc=20 v=1", IF_ID_PC, IF_ID_valid); end
      Br_taken = 1'b1; Br_offset = 32'hFFFF_FFFE;
      @(negedge clk);
      Br_taken = 1'b0; Br_offset = 32'h0;
      checks++; if (IF_ID_valid !== 1'b0 || IF_ID_PC !== 32'h0 || IF_ID_Instruction !== 32'h0) begin failures++; $display("FAIL branch_bubble got v=%0b pc=%h ins=%h exp 0/0/0", IF_ID_valid, IF_ID_PC, IF_ID_Instruction); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h18) begin failures++; $display("FAIL branch_req got req=%0b addr=%h exp req=1 addr=18", imem_req, imem_addr); end
      @(negedge clk);
      checks++; if (IF_ID_valid !== 1'b1 || IF_ID_PC !== 32'h1C || IF_ID_Instruction !== 32'h18 + K) begin failures++; $display("FAIL branch_target got v=%0b pc=%h ins=%h exp v=1 pc=1c ins=%h", IF_ID_valid, IF_ID_PC, IF_ID_Instruction, 32'h18 + K); end
   endtask

   task automatic test_drop;
      for (int i = 0; i < 20 && imem_addr !== 32'h40; i++) @(negedge clk);
      checks++; if (imem_addr !== 32'h40 || IF_ID_PC !== 32'h40 || IF_ID_valid !== 1'b1) begin failures++; $display("FAIL reach_40 got addr=%h pc=%h v=%0b exp addr=40 pc=40 v=1", imem_addr, IF_ID_PC, IF_ID_valid); end
      mem_lat = 3;
      Br_taken = 1'b1; Br_offset = 32'h4;
      @(negedge clk);
      Br_taken = 1'b0; Br_offset = 32'h0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || IF_ID_valid !== 1'b0) begin failures++; $display("FAIL drop_hold_addr got req=%0b addr=%h v=%0b exp req=1 addr=40 v=0", imem_req, imem_addr, IF_ID_valid); end
      repeat (2) @(negedge clk);
      checks++; if (imem_ack !== 1'b1 || imem_addr !== 32'h40 || IF_ID_valid !== 1'b0) begin failures++; $display("FAIL drop_ack got ack=%0b addr=%h v=%0b exp ack=1 addr=40 v=0", imem_ack, imem_addr, IF_ID_valid); end
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h50 || IF_ID_valid !== 1'b0) begin failures++; $display("FAIL drop_discard got req=%0b addr=%h v=%0b exp req=1 addr=50 v=0", imem_req, imem_addr, IF_ID_valid); end
      repeat (3) @(negedge clk);
      checks++; if (IF_ID_valid !== 1'b0) begin failures++; $display("FAIL drop_wait got v=%0b exp v=0", IF_ID_valid); end
      @(negedge clk);
      checks++; if (IF_ID_valid !== 1'b1 || IF_ID_PC !== 32'h54 || IF_ID_Instruction !== 32'h50 + K) begin failures++; $display("FAIL drop_target got v=%0b pc=%h ins=%h exp v=1 pc=54 ins=%h", IF_ID_valid, IF_ID_PC, IF_ID_Instruction, 32'h50 + K); end
   endtask

   task automatic test_branch_during_hazard;
      mem_lat = 0;
      hazard_Detected = 1'b1; Br_taken = 1'b1; Br_offset = 32'h8;
      @(negedge clk);
      checks++; if (IF_ID_valid !== 1'b1 || IF_ID_PC !== 32'h54 || IF_ID_Instruction !== 32'h50 + K || imem_req !== 1'b0) begin failures++; $display("FAIL br_hazard_frozen got v=%0b pc=%h ins=%h req=%0b exp v=1 pc=54 ins=%h req=0", IF_ID_valid, IF_ID_PC, IF_ID_Instruction, imem_req, 32'h50 + K); end
      hazard_Detected = 1'b0; Br_taken = 1'b0; Br_offset = 32'h0;
      @(negedge clk);
      checks++; if (IF_ID_PC !== 32'h58 || IF_ID_Instruction !== 32'h54 + K || imem_addr !== 32'h58) begin failures++; $display("FAIL br_hazard_ignored got pc=%h ins=%h addr=%h exp pc=58 ins=%h addr=58", IF_ID_PC, IF_ID_Instruction, imem_addr, 32'h54 + K); end
   endtask

   task automatic test_mid_reset;
      mem_lat = 3;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      ack_force = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0 || IF_ID_valid !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL mid_reset got req=%0b v=%0b addr=%h exp 0/0/0", imem_req, IF_ID_valid, imem_addr); end
      ack_force = 1'b0; mem_lat = 0;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || IF_ID_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_restart got req=%0b addr=%h v=%0b exp req=1 addr=0 v=0", imem_req, imem_addr, IF_ID_valid); end
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (stall_cycles !== 32'h0 || flush_count !== 32'h0) begin failures++; $display("FAIL perf_reset got stall=%0d flush=%0d exp 0/0", stall_cycles, flush_count); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      hazard_Detected = 1'b1;
      repeat (5) @(negedge clk);
      hazard_Detected = 1'b0;
      @(negedge clk);
      Br_taken = 1'b1;
      @(negedge clk);
      Br_taken = 1'b0;
      @(negedge clk);
      Br_taken = 1'b1;
      @(negedge clk);
      Br_taken = 1'b0;
      checks++; if (stall_cycles !== 32'd5) begin failures++; $display("FAIL perf_stall got=%0d exp=5", stall_cycles); end
      checks++; if (flush_count !== 32'd2) begin failures++; $display("FAIL perf_flush got=%0d exp=2", flush_count); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (stall_cycles !== 32'h0 || flush_count !== 32'h0) begin failures++; $display("FAIL perf_clear got stall=%0d flush=%0d exp 0/0", stall_cycles, flush_count); end
      rst = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_stall_hold();
      test_branch();
      test_drop();
      test_branch_during_hazard();
      test_mid_reset();
`ifdef FETCH_PERF_CNT_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage feeding the decode stage: owns the fetch PC, issues word requests to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register (instruction, PC+4, valid). It consumes decode's `hazard_Detected` (freeze) and `Br_taken` (flush and redirect) and returns the instruction stream that decode operates on. A one-entry hold buffer absorbs a fetch that completes while decode is stalled, so no fetched word is ever lost.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- hazard_Detected  in  1  decode stall; IF/ID register holds.
- Br_taken  in  1  decode branch/jump resolved taken.
- Br_offset  in  32  signed word offset of the taken branch.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  32  word-aligned byte address; stable while imem_req=1.
- imem_ack  in  1  response valid; may assert in the same cycle as imem_req.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- IF_ID_Instruction  out  32  registered instruction to decode.
- IF_ID_PC  out  32  registered address of that instruction + 4.
- IF_ID_valid  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- Definitions: advance = !IF_ID_valid | !hazard_Detected; redirect = IF_ID_valid & Br_taken & !hazard_Detected; target = IF_ID_PC + (Br_offset << 2), modulo 2^32.
- States: IDLE (no outstanding request), BUSY (request for fetch_pc outstanding), DROP (request outstanding; response is discarded). imem_req = (state != IDLE); imem_addr = address latched when the request was issued.
- Priority per edge: redirect > advance > stall.
- Redirect: IF/ID loaded with bubble (Instruction 0, PC 0, valid 0); hold buffer cleared; fetch_pc <= target. If a request is outstanding without ack this cycle -> DROP; otherwise -> BUSY issuing target.
- DROP: on ack, data discarded -> BUSY at fetch_pc. A further redirect while in DROP updates fetch_pc and stays in DROP.
- Advance, no redirect: IF/ID loads from hold buffer if hold_valid (hold cleared); else from imem_rdata if BUSY & ack; else bubble. When BUSY & ack, fetch_pc += 4 and state stays BUSY (back-to-back requests).
- Stall, no redirect: IF/ID unchanged. If BUSY & ack: word and its PC+4 written to hold buffer, fetch_pc += 4, state -> IDLE.
- IDLE -> BUSY when hold buffer is empty, or is draining into IF/ID this cycle.
- Br_taken with hazard_Detected=1 is ignored; decode re-presents it after the stall.

## Timing
- Reset (rst=0 at edge): state IDLE, fetch_pc=RESET_PC, hold empty; imem_req=0, imem_addr=0, IF_ID_Instruction=0, IF_ID_PC=0, IF_ID_valid=0. Reset mid-transaction abandons the request; a late ack is ignored.
- First request asserts in the first cycle after rst deasserts, address RESET_PC.
- Zero-wait memory (ack with req): request at cycle n -> IF_ID_valid at n+1; sustained one instruction per cycle.
- Redirect at edge n: target requested at n+1 (or after the old request's ack if in DROP); first target instruction valid at n+2 with zero-wait memory; exactly one bubble.
- Stall release with hold full: held word enters IF/ID on the first advance edge; the next request issues in the same cycle.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs stall_cycles[31:0] (+1 every cycle hazard_Detected=1 & IF_ID_valid=1) and flush_count[31:0] (+1 per redirect), both cleared by reset and wrapping at 2^32.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, zero-wait memory returning addr as data -> req addr 0 in cycle 1; IF_ID_PC = 4, 8, 12 on consecutive cycles, valid=1.
- hazard_Detected=1 for 3 cycles while ack arrives for addr 0x10 -> IF/ID frozen, req low after hold fills; on release IF/ID gets word@0x10, PC 0x14, then 0x14 requested.
- IF_ID_PC=0x20, Br_taken=1, Br_offset=-2 -> one bubble, next req addr 0x18, next IF_ID_PC=0x1C.
- 3-cycle memory latency, redirect while req for 0x40 pending -> DROP; old data discarded; target requested the cycle after ack.
- Br_taken=1 with hazard_Detected=1 -> no redirect, no flush, IF/ID unchanged.
- FETCH_PERF_CNT_EN: 5 stall cycles plus 2 redirects -> stall_cycles=5, flush_count=2; rst=0 clears both to 0.
